// File: rtl/alu_md_if.sv
// alu_md_if: operation/result bundle between the EX-stage issue logic and alu_md.
//   master: issue side (drives the operation, sees stall and results)
//   slave : alu_md side
//   in_valid/opcode/funct/rrs/rrt/imm/shamt : operation presented this cycle
//   stall      : operation not accepted, hold inputs
//   out_valid/rslt/ovf/illegal : registered result pulse
//   md_busy    : multiply/divide engine running
interface alu_md_if #(
  parameter int XLEN = 32
) ();
  localparam int SW = $clog2(XLEN);

  logic            in_valid;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [XLEN-1:0] rrs;
  logic [XLEN-1:0] rrt;
  logic [15:0]     imm;
  logic [SW-1:0]   shamt;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] rslt;
  logic            ovf;
  logic            illegal;
  logic            md_busy;

  modport master (
    output in_valid, opcode, funct, rrs, rrt, imm, shamt,
    input  stall, out_valid, rslt, ovf, illegal, md_busy
  );

  modport slave (
    input  in_valid, opcode, funct, rrs, rrt, imm, shamt,
    output stall, out_valid, rslt, ovf, illegal, md_busy
  );
endinterface

// File: rtl/alu_md.sv
// alu_md: EX-stage execute unit. Single-cycle registered ALU (add/sub, logic,
// compares, full-range fixed and variable shifts, LUI) plus an iterative
// MULT/DIV engine owning the HI/LO pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_md_if.slave (operation in, stall, registered result out)
// Result latency is one cycle for every op that produces a result. Ops that
// touch HI/LO stall while the engine is busy; plain ALU ops never stall.
module alu_md #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_md_if.slave  bus
);
  localparam int SW = $clog2(XLEN);

  // Instruction encodings (MIPS-I numbering)
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // Engine FSM
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  typedef enum logic [3:0] {
    SEL_ADD, SEL_AND, SEL_OR, SEL_XOR, SEL_NOR, SEL_SLT, SEL_SLTU,
    SEL_SLL, SEL_SRL, SEL_SRA, SEL_LUI, SEL_HI, SEL_LO, SEL_ZERO
  } sel_e;

  // Decode outputs
  sel_e            sel;
  logic [XLEN-1:0] op_b;
  logic [SW-1:0]   sh;
  logic            do_sub, ovf_en, has_res, bad;
  logic            md_class, md_go, md_signed, md_div, mt_hi, mt_lo;

  logic [XLEN-1:0] imm_se, imm_ze, b_eff, sum, res;
  logic            ovf_raw, accept;

  // Architectural and engine state
  logic [XLEN-1:0] hi, lo;
  logic [1:0]      state;
  logic [SW-1:0]   cnt;
  logic [XLEN-1:0] p_hi, p_lo, b_reg, a_save;
  logic            is_div, neg_q, neg_r, b_zero;

  assign imm_se = {{(XLEN-16){bus.imm[15]}}, bus.imm};
  assign imm_ze = {{(XLEN-16){1'b0}}, bus.imm};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    sel       = SEL_ZERO;
    op_b      = bus.rrt;
    sh        = bus.shamt;
    do_sub    = 1'b0;
    ovf_en    = 1'b0;
    has_res   = 1'b1;
    bad       = 1'b0;
    md_class  = 1'b0;
    md_go     = 1'b0;
    md_signed = 1'b0;
    md_div    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    if (bus.opcode == OP_SPECIAL) begin
      case (bus.funct)
        F_SLL:   sel = SEL_SLL;
        F_SRL:   sel = SEL_SRL;
        F_SRA:   sel = SEL_SRA;
        F_SLLV:  begin sel = SEL_SLL; sh = bus.rrs[SW-1:0]; end
        F_SRLV:  begin sel = SEL_SRL; sh = bus.rrs[SW-1:0]; end
        F_SRAV:  begin sel = SEL_SRA; sh = bus.rrs[SW-1:0]; end
        F_MFHI:  begin sel = SEL_HI; md_class = 1'b1; end
        F_MFLO:  begin sel = SEL_LO; md_class = 1'b1; end
        F_MTHI:  begin has_res = 1'b0; md_class = 1'b1; mt_hi = 1'b1; end
        F_MTLO:  begin has_res = 1'b0; md_class = 1'b1; mt_lo = 1'b1; end
        F_MULT:  begin has_res = 1'b0; md_class = 1'b1; md_go = 1'b1; md_signed = 1'b1; end
        F_MULTU: begin has_res = 1'b0; md_class = 1'b1; md_go = 1'b1; end
        F_DIV:   begin has_res = 1'b0; md_class = 1'b1; md_go = 1'b1; md_signed = 1'b1; md_div = 1'b1; end
        F_DIVU:  begin has_res = 1'b0; md_class = 1'b1; md_go = 1'b1; md_div = 1'b1; end
        F_ADD:   begin sel = SEL_ADD; ovf_en = 1'b1; end
        F_ADDU:  sel = SEL_ADD;
        F_SUB:   begin sel = SEL_ADD; do_sub = 1'b1; ovf_en = 1'b1; end
        F_SUBU:  begin sel = SEL_ADD; do_sub = 1'b1; end
        F_AND:   sel = SEL_AND;
        F_OR:    sel = SEL_OR;
        F_XOR:   sel = SEL_XOR;
        F_NOR:   sel = SEL_NOR;
        F_SLT:   sel = SEL_SLT;
        F_SLTU:  sel = SEL_SLTU;
        default: bad = 1'b1;
      endcase
    end else begin
      case (bus.opcode)
        OP_ADDI:  begin sel = SEL_ADD; op_b = imm_se; ovf_en = 1'b1; end
        OP_ADDIU: begin sel = SEL_ADD; op_b = imm_se; end
        OP_LW:    begin sel = SEL_ADD; op_b = imm_se; end
        OP_SW:    begin sel = SEL_ADD; op_b = imm_se; end
        OP_SLTI:  begin sel = SEL_SLT; op_b = imm_se; end
        OP_SLTIU: begin sel = SEL_SLTU; op_b = imm_se; end
        OP_ANDI:  begin sel = SEL_AND; op_b = imm_ze; end
        OP_ORI:   begin sel = SEL_OR; op_b = imm_ze; end
        OP_XORI:  begin sel = SEL_XOR; op_b = imm_ze; end
        OP_LUI:   sel = SEL_LUI;
        default:  bad = 1'b1;
      endcase
    end
  end

  // Shared adder; subtraction is a + ~b + 1. Overflow looks at the effective
  // second operand, so SUB flags on the inverted sign.
  assign b_eff   = do_sub ? ~op_b : op_b;
  assign sum     = bus.rrs + b_eff + XLEN'(do_sub);
  assign ovf_raw = (bus.rrs[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != bus.rrs[XLEN-1]);

  always_comb begin
    res = '0;
    case (sel)
      SEL_ADD:  res = sum;
      SEL_AND:  res = bus.rrs & op_b;
      SEL_OR:   res = bus.rrs | op_b;
      SEL_XOR:  res = bus.rrs ^ op_b;
      SEL_NOR:  res = ~(bus.rrs | op_b);
      SEL_SLT:  res = XLEN'($signed(bus.rrs) < $signed(op_b));
      SEL_SLTU: res = XLEN'(bus.rrs < op_b);
      SEL_SLL:  res = bus.rrt << sh;
      SEL_SRL:  res = bus.rrt >> sh;
      SEL_SRA:  res = $signed(bus.rrt) >>> sh;
      SEL_LUI:  res = imm_ze << 16;
      SEL_HI:   res = hi;
      SEL_LO:   res = lo;
      default:  res = '0;
    endcase
  end

  assign bus.md_busy = (state != S_IDLE);
  assign bus.stall   = bus.in_valid & bus.md_busy & md_class;
  assign accept      = bus.in_valid & ~bus.stall;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.rslt      <= '0;
      bus.ovf       <= 1'b0;
      bus.illegal   <= 1'b0;
    end else begin
      bus.out_valid <= accept & has_res;
      if (accept && has_res) begin
        bus.rslt    <= res;
        bus.ovf     <= ovf_en & ovf_raw;
        bus.illegal <= bad;
      end
    end
  end

  // Engine: operands reduced to magnitudes at accept. Both mult and div start
  // with p_hi=0, p_lo=|a|, b_reg=|b|.
  //  mult: shift-add, multiplier bits consumed from p_lo[0], product shifts in.
  //  div : restoring, dividend bits leave p_lo MSB, quotient bits enter LSB,
  //        remainder accumulates in p_hi.
  logic            sa, sb;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod;

  assign sa        = md_signed & bus.rrs[XLEN-1];
  assign sb        = md_signed & bus.rrt[XLEN-1];
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_reg} : '0);
  assign div_shift = {p_hi, p_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign prod      = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      b_reg  <= '0;
      a_save <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && md_go) begin
            state  <= S_RUN;
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= sa ? -bus.rrs : bus.rrs;
            b_reg  <= sb ? -bus.rrt : bus.rrt;
            a_save <= bus.rrs;
            is_div <= md_div;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (bus.rrt == '0);
          end
        end
        S_RUN: begin
          if (is_div) begin
            if (!div_diff[XLEN]) begin
              p_hi <= div_diff[XLEN-1:0];
              p_lo <= {p_lo[XLEN-2:0], 1'b1};
            end else begin
              p_hi <= {p_hi[XLEN-2:0], p_lo[XLEN-1]};
              p_lo <= {p_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            p_hi <= mul_sum[XLEN:1];
            p_lo <= {mul_sum[0], p_lo[XLEN-1:1]};
          end
          if (cnt == SW'(XLEN-1)) begin
            state <= S_FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;  // S_FIX: HI/LO written below
      endcase
    end
  end

  // NOTE: HI/LO are architectural registers that must read as zero after
  // reset (including a reset that aborts the engine), so they are reset
  // explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      if (!is_div) begin
        {hi, lo} <= prod;
      end else if (b_zero) begin
        lo <= '1;
        hi <= a_save;
      end else begin
        lo <= neg_q ? -p_lo : p_lo;
        hi <= neg_r ? -p_hi : p_hi;
      end
    end else begin
      if (accept && mt_hi) hi <= bus.rrs;
      if (accept && mt_lo) lo <= bus.rrs;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;
  localparam int XLEN = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_md_if #(.XLEN(XLEN)) bus ();
  alu_md #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [XLEN-1:0] rslt;
    logic            ovf;
    logic            illegal;
    string           name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  int   stall_cnt = 0;
  int   pops = 0;

  // Scoreboard sampling on the falling edge: pop one expectation per pulse.
  task automatic sample();
    exp_t e;
    if (bus.md_busy) busy_cnt++;
    if (bus.in_valid && bus.stall) stall_cnt++;
    if (rst_n && bus.out_valid) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: out_valid with rslt=%h, no result expected", bus.rslt);
      end else begin
        e = sb_q.pop_front();
        pops++;
        if (bus.rslt !== e.rslt || bus.ovf !== e.ovf || bus.illegal !== e.illegal) begin
          n_fail++;
          $display("FAIL %s: got rslt=%h ovf=%b illegal=%b, want rslt=%h ovf=%b illegal=%b",
                   e.name, bus.rslt, bus.ovf, bus.illegal, e.rslt, e.ovf, e.illegal);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                       input logic [4:0] sh, input bit has_out, input logic [31:0] er,
                       input logic eo, input logic ei);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.rrs      = rs;
    bus.rrt      = rt;
    bus.imm      = im;
    bus.shamt    = sh;
    for (int w = 0; w < 200 && !acc; w++) begin
      @(negedge clk);
      sample();
      if (!bus.stall) begin
        acc = 1'b1;
        if (has_out) sb_q.push_back('{er, eo, ei, name});
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: still stalled after 200 cycles, want accepted", name);
    end
  endtask

  task automatic rop(input string name, input logic [5:0] fn, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [4:0] sh, input logic [31:0] er,
                     input logic eo);
    issue(name, OP_SPECIAL, fn, rs, rt, 16'h0, sh, 1'b1, er, eo, 1'b0);
  endtask

  task automatic iop(input string name, input logic [5:0] op, input logic [31:0] rs,
                     input logic [15:0] im, input logic [31:0] er, input logic eo);
    issue(name, op, 6'h0, rs, 32'h0, im, 5'd0, 1'b1, er, eo, 1'b0);
  endtask

  task automatic md(input string name, input logic [5:0] fn, input logic [31:0] rs,
                    input logic [31:0] rt);
    issue(name, OP_SPECIAL, fn, rs, rt, 16'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 100 && sb_q.size() > 0; w++) tick();
    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [XLEN+4:0] obs;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.funct    = '0;
    bus.rrs      = '0;
    bus.rrt      = '0;
    bus.imm      = '0;
    bus.shamt    = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.out_valid, bus.rslt, bus.ovf, bus.illegal, bus.md_busy, bus.stall};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", obs);
    end
    rst_n = 1'b1;
    tick();
    rop("reset_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    rop("reset_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    drain("reset");
  endtask

  task automatic test_alu();
    rop("addu_wrap", F_ADDU, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    rop("add_ovf",   F_ADD,  32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1);
    rop("subu_wrap", F_SUBU, 32'h0, 32'h1, 5'd0, 32'hFFFFFFFF, 1'b0);
    rop("sub_ovf",   F_SUB,  32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1);
    rop("sra_31",    F_SRA,  32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0);
    rop("srlv_36",   F_SRLV, 32'd36, 32'hF0, 5'd0, 32'h0F, 1'b0);
    rop("sltu",      F_SLTU, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h1, 1'b0);
    rop("slt",       F_SLT,  32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0);
    rop("sll_0",     F_SLL,  32'h0, 32'h1, 5'd0, 32'h1, 1'b0);
    rop("sll_31",    F_SLL,  32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0);
    rop("nor",       F_NOR,  32'h0F0F0F0F, 32'h00FF00FF, 5'd0, 32'hF000F000, 1'b0);
    iop("andi_zext", OP_ANDI,  32'hFFFFFFFF, 16'h8000, 32'h00008000, 1'b0);
    iop("xori_zext", OP_XORI,  32'hFFFF0000, 16'hFFFF, 32'hFFFFFFFF, 1'b0);
    iop("addi_sext", OP_ADDI,  32'h0, 16'hFFFF, 32'hFFFFFFFF, 1'b0);
    iop("addi_ovf",  OP_ADDI,  32'h80000000, 16'hFFFF, 32'h7FFFFFFF, 1'b1);
    iop("slti",      OP_SLTI,  32'h5, 16'hFFFF, 32'h0, 1'b0);
    iop("sltiu",     OP_SLTIU, 32'h5, 16'hFFFF, 32'h1, 1'b0);
    iop("lui",       OP_LUI,   32'hFFFFFFFF, 16'h1234, 32'h12340000, 1'b0);
    iop("lw_addr",   OP_LW,    32'h1000, 16'hFFFC, 32'h00000FFC, 1'b0);
    issue("illegal_op", 6'h3F, 6'h0, 32'h5, 32'h5, 16'h5, 5'd0, 1'b1, 32'h0, 1'b0, 1'b1);
    issue("illegal_fn", OP_SPECIAL, 6'h01, 32'h5, 32'h5, 16'h0, 5'd0, 1'b1, 32'h0, 1'b0, 1'b1);
    drain("alu");
  endtask

  task automatic test_mult();
    md("mult", F_MULT, 32'hFFFFFFFD, 32'd7);
    busy_cnt  = 0;
    stall_cnt = 0;
    rop("mult_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFEB, 1'b0);
    // MFLO waits out the whole busy window: XLEN RUN cycles plus FIX
    n_tests++;
    if (busy_cnt !== XLEN + 1) begin
      n_fail++;
      $display("FAIL mult_busy_cycles: got %0d, want %0d", busy_cnt, XLEN + 1);
    end
    n_tests++;
    if (stall_cnt !== XLEN + 1) begin
      n_fail++;
      $display("FAIL mult_stall_cycles: got %0d, want %0d", stall_cnt, XLEN + 1);
    end
    rop("mult_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
    md("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rop("multu_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFE, 1'b0);
    rop("multu_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'h00000001, 1'b0);
    drain("mult");
  endtask

  task automatic test_div();
    md("div", F_DIV, 32'hFFFFFFF9, 32'd2);
    rop("div_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFD, 1'b0);
    rop("div_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
    md("divu0", F_DIVU, 32'h1234, 32'h0);
    rop("divu0_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
    rop("divu0_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'h00001234, 1'b0);
    md("div_min", F_DIV, 32'h80000000, 32'hFFFFFFFF);
    rop("div_min_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'h80000000, 1'b0);
    rop("div_min_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    md("div_negb", F_DIV, 32'd7, 32'hFFFFFFFE);
    rop("div_negb_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFD, 1'b0);
    rop("div_negb_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'h1, 1'b0);
    md("div0", F_DIV, 32'hFFFFFFFB, 32'h0);
    rop("div0_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
    rop("div0_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFB, 1'b0);
    md("mthi", F_MTHI, 32'h0000DEAD, 32'h0);
    md("mtlo", F_MTLO, 32'h0000BEEF, 32'h0);
    rop("mt_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'h0000DEAD, 1'b0);
    rop("mt_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'h0000BEEF, 1'b0);
    drain("div");
  endtask

  task automatic test_back_to_back();
    int p0;
    md("b2b_div", F_DIV, 32'd100, 32'd7);
    stall_cnt = 0;
    p0 = pops;
    for (int i = 0; i < 10; i++)
      iop($sformatf("b2b_addi%0d", i), OP_ADDI, 32'(i * 1000), 16'(i), 32'(i * 1001), 1'b0);
    n_tests++;
    if (stall_cnt !== 0) begin
      n_fail++;
      $display("FAIL b2b_alu_stall: got %0d stall cycles, want 0", stall_cnt);
    end
    md("b2b_divu", F_DIVU, 32'hFFFFFFF0, 32'd3);
    n_tests++;
    if (stall_cnt == 0) begin
      n_fail++;
      $display("FAIL b2b_divu_stall: got 0 stall cycles, want >0");
    end
    n_tests++;
    if (pops - p0 !== 10) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d results, want 10", pops - p0);
    end
    rop("b2b_divu_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'h55555550, 1'b0);
    rop("b2b_divu_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    // Operands change right after the DIV is accepted; result must not move.
    md("latch_div", F_DIV, 32'd100, 32'd7);
    iop("latch_addi0", OP_ADDI, 32'h12345678, 16'h0001, 32'h12345679, 1'b0);
    rop("latch_addu", F_ADDU, 32'hDEADBEEF, 32'h1, 5'd0, 32'hDEADBEF0, 1'b0);
    rop("latch_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'd14, 1'b0);
    rop("latch_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'd2, 1'b0);
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    logic [XLEN+1:0] obs;
    md("mid_div", F_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (11) tick();
    // ADDI accepted on the 12th engine edge; its pulse is killed by reset
    issue("mid_addi", OP_ADDI, 32'd5, 16'd5, 5'd0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    obs = {bus.md_busy, bus.out_valid, bus.rslt};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h, want 0", obs);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    rop("mid_lo", F_MFLO, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    rop("mid_hi", F_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
